// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a byte-lane data memory.
// One request in flight: IDLE -> ACCESS (memory cycle) -> RESP (held until consumed).
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_enable,
  output logic        store_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] MEM_LIMIT = MEM_BYTES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_r;
  state_e      next_state_s;
  logic        is_store_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_misaligned_r;
  logic        resp_fault_r;

  logic        is_half_s;
  logic        is_word_s;
  logic        illegal_s;
  logic        misaligned_s;
  logic        fault_s;
  logic        store_enable_s;
  logic [31:0] lane_data_s;
  logic [3:0]  lane_we_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_data_s;

  assign req_ready        = (state_r == IDLE);
  assign resp_valid       = resp_valid_r;
  assign resp_rdata       = resp_rdata_r;
  assign resp_misaligned  = resp_misaligned_r;
  assign resp_fault       = resp_fault_r;
  assign mem_address      = addr_r;
  assign mem_write_data   = lane_data_s;
  assign mem_write_enable = lane_we_s;
  assign store_enable     = store_enable_s;

  assign is_half_s    = (funct3_r[1:0] == 2'b01);
  assign is_word_s    = (funct3_r[1:0] == 2'b10);
  assign misaligned_s = (is_half_s & addr_r[0]) | (is_word_s & (addr_r[1:0] != 2'b00));
  assign fault_s      = illegal_s | (addr_r >= MEM_LIMIT);
  // reset_n gates the strobe so a reset during ACCESS can never leave a partial write
  assign store_enable_s = (state_r == ACCESS) & is_store_r & ~misaligned_s & ~fault_s & reset_n;

  // Legal width codes: stores only use 000/001/010, loads additionally 100/101
  always_comb begin
    illegal_s = 1'b1;
    case (funct3_r)
      3'b000:  illegal_s = 1'b0;
      3'b001:  illegal_s = 1'b0;
      3'b010:  illegal_s = 1'b0;
      3'b100:  illegal_s = is_store_r;
      3'b101:  illegal_s = is_store_r;
      default: illegal_s = 1'b1;
    endcase
  end

  // Replicate store data across lanes and form byte strobes, zero unless writing
  always_comb begin
    lane_data_s = 32'h0000_0000;
    lane_we_s   = 4'b0000;
    if (store_enable_s) begin
      case (funct3_r[1:0])
        2'b00: begin
          lane_data_s = {4{wdata_r[7:0]}};
          lane_we_s   = 4'b0001 << addr_r[1:0];
        end
        2'b01: begin
          lane_data_s = {2{wdata_r[15:0]}};
          lane_we_s   = 4'b0011 << {addr_r[1], 1'b0};
        end
        2'b10: begin
          lane_data_s = wdata_r;
          lane_we_s   = 4'b1111;
        end
        default: begin
          lane_data_s = 32'h0000_0000;
          lane_we_s   = 4'b0000;
        end
      endcase
    end else begin
      lane_data_s = 32'h0000_0000;
      lane_we_s   = 4'b0000;
    end
  end

  assign byte_s = mem_read_data[{addr_r[1:0], 3'b000} +: 8];
  assign half_s = mem_read_data[{addr_r[1], 4'b0000} +: 16];

  // Extend the selected lane according to the load width code
  always_comb begin
    load_data_s = 32'h0000_0000;
    case (funct3_r)
      3'b000:  load_data_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  load_data_s = {{16{half_s[15]}}, half_s};
      3'b010:  load_data_s = mem_read_data;
      3'b100:  load_data_s = {24'h00_0000, byte_s};
      3'b101:  load_data_s = {16'h0000, half_s};
      default: load_data_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic; RESP waits for the consumer before returning to IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: next_state_s = RESP;
      RESP: begin
        if (resp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, captured request and registered response
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r           <= IDLE;
      is_store_r        <= 1'b0;
      funct3_r          <= 3'b000;
      addr_r            <= 32'h0000_0000;
      wdata_r           <= 32'h0000_0000;
      resp_valid_r      <= 1'b0;
      resp_rdata_r      <= 32'h0000_0000;
      resp_misaligned_r <= 1'b0;
      resp_fault_r      <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == IDLE) && req_valid) begin
        is_store_r <= req_is_store;
        funct3_r   <= req_funct3;
        addr_r     <= req_addr;
        wdata_r    <= req_wdata;
      end
      if (state_r == ACCESS) begin
        resp_valid_r      <= 1'b1;
        resp_misaligned_r <= misaligned_s;
        resp_fault_r      <= fault_s;
        resp_rdata_r      <= (is_store_r | misaligned_s | fault_s) ? 32'h0000_0000 : load_data_s;
      end else if ((state_r == RESP) && resp_ready) begin
        // rdata deliberately keeps its last value after the handshake
        resp_valid_r      <= 1'b0;
        resp_misaligned_r <= 1'b0;
        resp_fault_r      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/backpressure sequences,
// then random traffic checked against a byte-array reference model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_enable;
  logic        store_enable;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .store_enable(store_enable),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  // Byte-lane data memory: combinational read, strobed write
  assign mem_read_data = {mem[{mem_address[7:2], 2'b11}], mem[{mem_address[7:2], 2'b10}],
                          mem[{mem_address[7:2], 2'b01}], mem[{mem_address[7:2], 2'b00}]};
  always @(posedge clock) begin
    if (store_enable) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_write_enable[i]) mem[{mem_address[7:2], i[1:0]}] <= mem_write_data[8*i +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: access size from funct3, natural alignment, little-endian byte array
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic mis, output logic flt);
    int sz;
    logic [31:0] v;
    case (f3)
      3'd0: sz = 1;
      3'd1: sz = 2;
      3'd2: sz = 4;
      3'd4: sz = st ? 0 : 1;
      3'd5: sz = st ? 0 : 2;
      default: sz = 0;
    endcase
    mis = (sz != 0) && ((a % sz) != 0);
    flt = (sz == 0) || (a >= 32'd256);
    rd = 32'd0;
    if (!mis && !flt) begin
      if (st) begin
        for (int i = 0; i < sz; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[a + i]) << (8*i));
        if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
        rd = v;
      end
    end
  endtask

  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd, output logic mis, output logic flt,
                     output logic [3:0] we_acc, output logic [31:0] wd_acc, output logic [31:0] ma_acc,
                     output int se_cnt);
    int n;
    logic [31:0] held;
    @(negedge clock);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clock); n++; end
    check("accept_ready", 32'(req_ready), 32'd1);
    @(negedge clock);
    // garbage on the request side must be ignored from here on
    req_valid = 1'($urandom); req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    we_acc = mem_write_enable; wd_acc = mem_write_data; ma_acc = mem_address;
    se_cnt = int'(store_enable);
    check("ready_low_access", 32'(req_ready), 32'd0);
    @(negedge clock);
    n = 0;
    while (!resp_valid && n < 10) begin @(negedge clock); n++; end
    check("resp_latency", n, 32'd0);
    rd = resp_rdata; mis = resp_misaligned; flt = resp_fault; held = resp_rdata;
    se_cnt += int'(store_enable);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", {req_ready, resp_valid}, 32'b01);
      check("hold_rdata", resp_rdata, held);
      se_cnt += int'(store_enable);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0; req_valid = 1'b0;
    check("resp_cleared", {resp_valid, resp_misaligned, resp_fault}, 32'd0);
    check("rdata_kept", resp_rdata, held);
    check("idle_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd, output logic mis, output logic flt,
                     output logic [3:0] we_acc, output logic [31:0] wd_acc);
    logic [31:0] erd, ma;
    logic emis, eflt;
    int se;
    model(st, f3, a, wd, erd, emis, eflt);
    txn(st, f3, a, wd, hold, rd, mis, flt, we_acc, wd_acc, ma, se);
    check("model_rdata", rd, erd);
    check("model_flags", {mis, flt}, {emis, eflt});
    check("store_pulses", se, (st && !emis && !eflt) ? 32'd1 : 32'd0);
    check("mem_address", ma, a);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          hold;
    logic [31:0] rd;
    logic        mis;
    logic        flt;
    logic [3:0]  we;
    logic [31:0] wdat;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [31:0] rd, wdat;
    logic mis, flt;
    logic [3:0] we;
    int bad;

    tbl[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 32'h0,        1'b0, 1'b0, 4'b1111, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        5, 32'hDEADBEEF, 1'b0, 1'b0, 4'b0000, 32'h0};
    tbl[2]  = '{1'b1, 3'b000, 32'h13,  32'h000000A5, 0, 32'h0,        1'b0, 1'b0, 4'b1000, 32'hA5A5A5A5};
    tbl[3]  = '{1'b0, 3'b000, 32'h13,  32'h0,        0, 32'hFFFFFFA5, 1'b0, 1'b0, 4'b0000, 32'h0};
    tbl[4]  = '{1'b0, 3'b100, 32'h13,  32'h0,        1, 32'h000000A5, 1'b0, 1'b0, 4'b0000, 32'h0};
    tbl[5]  = '{1'b1, 3'b001, 32'h22,  32'h00008001, 0, 32'h0,        1'b0, 1'b0, 4'b1100, 32'h80018001};
    tbl[6]  = '{1'b0, 3'b001, 32'h22,  32'h0,        0, 32'hFFFF8001, 1'b0, 1'b0, 4'b0000, 32'h0};
    tbl[7]  = '{1'b0, 3'b101, 32'h22,  32'h0,        0, 32'h00008001, 1'b0, 1'b0, 4'b0000, 32'h0};
    tbl[8]  = '{1'b1, 3'b010, 32'h11,  32'h12345678, 0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0};
    tbl[9]  = '{1'b0, 3'b001, 32'h21,  32'h0,        0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0};
    tbl[10] = '{1'b0, 3'b010, 32'h10,  32'h0,        0, 32'hA5ADBEEF, 1'b0, 1'b0, 4'b0000, 32'h0};
    tbl[11] = '{1'b1, 3'b010, 32'h100, 32'h00000001, 0, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0};
    tbl[12] = '{1'b0, 3'b011, 32'h10,  32'h0,        0, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0};
    tbl[13] = '{1'b0, 3'b010, 32'h101, 32'h0,        0, 32'h0,        1'b1, 1'b1, 4'b0000, 32'h0};
    tbl[14] = '{1'b1, 3'b100, 32'h20,  32'hCAFEF00D, 0, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0};
    tbl[15] = '{1'b0, 3'b010, 32'h20,  32'h0,        0, 32'h80010000, 1'b0, 1'b0, 4'b0000, 32'h0};

    reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_resp", {resp_valid, resp_misaligned, resp_fault, store_enable}, 32'd0);
    check("reset_rdata", resp_rdata, 32'd0);
    check("reset_address", mem_address, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].hold, rd, mis, flt, we, wdat);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      check($sformatf("vec%0d_flags", i), {mis, flt}, {tbl[i].mis, tbl[i].flt});
      check($sformatf("vec%0d_strobes", i), 32'(we), 32'(tbl[i].we));
      check($sformatf("vec%0d_wdata", i), wdat, tbl[i].wdat);
    end

    // Reset asserted while an SW is in ACCESS: no write, back to IDLE
    @(negedge clock);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'h11223344;
    @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_access_no_store", 32'(store_enable), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    check("rst_idle_ready", 32'(req_ready), 32'd1);
    check("rst_resp_clear", {resp_valid, resp_misaligned, resp_fault}, 32'd0);
    check("rst_address", mem_address, 32'd0);
    run(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, mis, flt, we, wdat);
    check("rst_mem_untouched", rd, 32'd0);

    for (int k = 0; k < 200; k++) begin
      logic st;
      logic [2:0] f3;
      logic [31:0] a;
      logic legal;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
      legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
      if (!legal) a[1:0] = 2'b00;
      run(st, f3, a, $urandom, int'($urandom_range(0, 2)), rd, mis, flt, we, wdat);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
